// File: rtl/matmul_dot_accumulator.sv
// Dot-product accumulator behind the signed product multiplier: sums K products per
// output element, saturates each result to DOUT_WIDTH and queues it in a small output FIFO.
module matmul_dot_accumulator #(
   parameter int DIN_WIDTH  = 32,
   parameter int ACC_WIDTH  = 48,
   parameter int DOUT_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int OUT_DEPTH  = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [CNT_WIDTH-1:0]  cfg_k,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN_WIDTH-1:0]  in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] out_data,
   output logic                  out_sat,
   output logic                  out_len_err,
   output logic                  busy,
   output logic [31:0]           dot_count
);

   localparam int PTR_W = $clog2(OUT_DEPTH);

   localparam logic [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   typedef struct packed {
      logic [DOUT_WIDTH-1:0] data;
      logic                  sat;
      logic                  len_err;
   } result_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 cnt_ovf_q;
   logic [CNT_WIDTH-1:0] k_q;
   logic                 rst_n_q;
   result_t              mem_q [OUT_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]       fill_q;
   logic [31:0]          dot_count_q;

   logic                 beat, first, push, pop, fifo_full;
   logic [ACC_WIDTH-1:0] addend, sum;
   logic [CNT_WIDTH-1:0] cnt_next, k_eff;
   logic                 ovf_next;
   result_t              result;

   assign fifo_full = (fill_q == (PTR_W+1)'(OUT_DEPTH));
   // Based only on registered state, so out_ready never reaches in_ready combinationally.
   assign in_ready  = rst_n_q && !fifo_full;
   assign beat      = in_valid && in_ready;
   assign first     = (state_q == S_IDLE);
   assign push      = beat && in_last;
   assign out_valid = (fill_q != '0);
   assign pop       = out_valid && out_ready;

   assign out_data    = mem_q[rd_ptr_q].data;
   assign out_sat     = mem_q[rd_ptr_q].sat;
   assign out_len_err = mem_q[rd_ptr_q].len_err;
   assign busy        = (state_q == S_ACCUM) || out_valid;
   assign dot_count   = dot_count_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      addend   = ACC_WIDTH'($signed(in_data));
      sum      = (first ? '0 : acc_q) + addend;
      cnt_next = first ? CNT_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1));
      // A beat arriving with the counter pinned at all-ones makes the length unrepresentable.
      ovf_next = first ? 1'b0 : (cnt_ovf_q || (&cnt_q));
      k_eff    = first ? cfg_k : k_q;

      result.sat     = 1'b0;
      result.data    = sum[DOUT_WIDTH-1:0];
      result.len_err = ovf_next || (cnt_next != k_eff);
      if ($signed(sum) > $signed(SAT_MAX)) begin
         result.sat  = 1'b1;
         result.data = SAT_MAX[DOUT_WIDTH-1:0];
      end else if ($signed(sum) < $signed(SAT_MIN)) begin
         result.sat  = 1'b1;
         result.data = SAT_MIN[DOUT_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      if (beat) state_d = in_last ? S_IDLE : S_ACCUM;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         rst_n_q   <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         cnt_ovf_q <= 1'b0;
         k_q       <= '0;
      end else begin
         rst_n_q <= 1'b1;
         if (beat) begin
            acc_q     <= sum;
            cnt_q     <= push ? '0 : cnt_next;
            cnt_ovf_q <= push ? 1'b0 : ovf_next;
            if (first) k_q <= cfg_k;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         // NOTE: the FIFO storage is reset because its head drives the outputs directly.
         for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         dot_count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= result;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            dot_count_q     <= dot_count_q + 32'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   fill_q <= fill_q + (PTR_W+1)'(1);
            2'b01:   fill_q <= fill_q - (PTR_W+1)'(1);
            default: fill_q <= fill_q;
         endcase
      end
   end

endmodule

// File: doc/matmul_dot_accumulator.md
Name: matmul_dot_accumulator

Overview:
Downstream stage of the 32-bit signed pipelined multiplier in the matrix-multiplication kernel. Consumes the stream of signed products, sums K products per output element into a wide accumulator, then emits one saturated DOUT_WIDTH result per dot product. Results pass through a small output FIFO so accumulation continues while the consumer stalls. Flags length mismatches and saturation per result.

Parameters:
DIN_WIDTH, 32, width of signed product input (multiplier dout width)
ACC_WIDTH, 48, signed accumulator width; must be >= DIN_WIDTH
DOUT_WIDTH, 32, signed result width; must be <= ACC_WIDTH
CNT_WIDTH, 16, width of beat counter and cfg_k
OUT_DEPTH, 2, output FIFO entries (power of two, >= 2)

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  synchronous active-low reset
cfg_k  in  CNT_WIDTH  expected products per dot; sampled on first beat of each dot
in_valid  in  1  product beat valid
in_ready  out  1  stage can accept a beat
in_data  in  DIN_WIDTH  signed product
in_last  in  1  final product of the current dot
out_valid  out  1  result available at FIFO head
out_ready  in  1  consumer accepts result
out_data  out  DOUT_WIDTH  saturated signed dot result
out_sat  out  1  result was clipped
out_len_err  out  1  beat count != sampled cfg_k
busy  out  1  dot in progress or FIFO non-empty
dot_count  out  32  total results pushed since reset, wraps

Behaviour:
- Reset (ap_rst_n=0 at a rising edge): state=IDLE, acc=0, beat count=0, k_latched=0, FIFO emptied, dot_count=0. Outputs: in_ready=0 during reset, out_valid=0, out_data=0, out_sat=0, out_len_err=0, busy=0. Reset mid-dot discards the partial sum; no result is emitted.
- Beat accepted when in_valid && in_ready. in_ready = ap_rst_n_q && !fifo_full (registered-full based; no combinational out_ready->in_ready path).
- FSM: IDLE (count==0) / ACCUM.
  - IDLE + accepted beat: acc <= sext(in_data); count <= 1; k_latched <= cfg_k. If in_last, push at this edge (single-beat dot) and stay IDLE; else go to ACCUM.
  - ACCUM + accepted beat: acc <= acc + sext(in_data) modulo 2^ACC_WIDTH (wraps, no sticky overflow); count++. If in_last: push, count <= 0, go to IDLE.
  - No accepted beat: hold.
- Push value is computed from the post-add sum S (the value including the last beat):
  - out_data = S clipped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - out_sat = 1 iff clipping occurred.
  - out_len_err = 1 iff the final beat number != k_latched; cfg_k=0 always sets the error.
- Count saturates at all-ones; no wrap. A dot longer than 2^CNT_WIDTH-1 beats always flags len_err.
- Latency: a last beat accepted at edge N gives out_valid=1 from cycle N+1 if the FIFO was empty. Throughput is one beat per cycle while the FIFO is not full.
- FIFO: registered head outputs. A pop occurs when out_valid && out_ready. A simultaneous push and pop on a non-empty FIFO keeps the occupancy unchanged and preserves order. When full, in_ready=0 the whole cycle, even if a pop occurs that cycle; in_ready reasserts the next cycle.
- out_data/out_sat/out_len_err hold stable while out_valid && !out_ready.
- dot_count increments on every push.
- busy = (state==ACCUM) || fifo_nonempty.

Test Plan:
- cfg_k=4, products 10,-3,7,100 (last on 4th), out_ready=1 -> one result, out_data=114, sat=0, len_err=0, out_valid exactly one cycle after last beat, dot_count=1.
- cfg_k=2, products 0x7FFFFFFF, 0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1; repeat with 0x80000000 twice -> out_data=0x80000000, out_sat=1.
- out_ready=0; three back-to-back single-beat dots (cfg_k=1, data 1,2,3) -> in_ready falls after 2 pushes, third beat stalls. Release out_ready -> results 1,2,3 in order, no loss or duplication.
- cfg_k=3, send 2 beats with last on 2nd -> out_len_err=1, sum correct. cfg_k=0 single beat -> len_err=1.
- Reset asserted after 2 of 4 beats, then a fresh dot cfg_k=2 with 5,6 -> only result is 11, dot_count=1, no stale partial sum.
- Random valid/ready toggling, 200 dots with random lengths 1..16 vs reference model -> exact match of all data and flags, busy=0 at end.
